// File: rtl/inertial_integrator_gen.sv
// inertial_integrator_gen
//   Fuses a raw pitch-rate gyro sample and a raw Z-accelerometer sample into a
//   pitch angle. The gyro rate (offset-compensated) is integrated, and the
//   integrator is nudged by a fixed step toward the accelerometer-derived angle
//   on every accepted sample. A FAST phase uses a large nudge so the estimate
//   converges quickly. After FAST_CNT samples the design moves to RUN, which
//   uses a small nudge.
//
//   Optional feature (macro INERTIAL_INTEGRATOR_GEN_CAL_EN):
//     defined   -> a CAL phase averages 2^CAL_LOG2 rate samples to learn the gyro
//                  offset, then seeds the integrator from the accelerometer.
//     undefined -> no CAL logic. The fixed PTCH_RT_OFFSET is used, the design
//                  starts in FAST with the integrator at 0, and cal_done is
//                  tied high.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   vld      in   one-cycle strobe, ptch_rt/AZ valid this cycle
//   ptch_rt  in   W-bit signed raw pitch rate
//   AZ       in   W-bit signed raw Z acceleration
//   ptch     out  W-bit signed fused pitch, integrator[INT_W-1:SHIFT]
//   ptch_vld out  pulses the cycle after each accepted sample outside CAL
//   cal_done out  high once calibration has completed
module inertial_integrator_gen #(
  parameter int            W              = 16,
  parameter int            INT_W          = 27,
  parameter int            SHIFT          = 11,
  parameter logic [W-1:0]  PTCH_RT_OFFSET = 16'h03C2,
  parameter logic [W-1:0]  AZ_OFFSET      = 16'hFE80,
  parameter int            FUDGE          = 327,
  parameter int            ACC_SHIFT      = 13,
  parameter int            FUSE_LOG2      = 10,
  parameter int            FAST_LOG2      = 13,
  parameter int            FAST_CNT       = 256,
  parameter int            CAL_LOG2       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] ptch_rt,
  input  logic [W-1:0] AZ,
  output logic [W-1:0] ptch,
  output logic         ptch_vld,
  output logic         cal_done
);

  localparam int PW  = W + 12;
  localparam int FCW = $clog2(FAST_CNT + 1);
  localparam logic signed [11:0]      FUDGE_S   = 12'(FUDGE);
  localparam logic signed [INT_W-1:0] STEP_FAST = INT_W'(2 ** FAST_LOG2);
  localparam logic signed [INT_W-1:0] STEP_RUN  = INT_W'(2 ** FUSE_LOG2);

  typedef enum logic [1:0] {S_CAL, S_FAST, S_RUN} state_t;

  // Accelerometer-to-angle conversion: (az_comp * FUDGE) >>> ACC_SHIFT.
  // The low W bits are kept.
  function automatic logic signed [W-1:0] accel_to_angle(input logic signed [W-1:0] a);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(FUDGE_S);
    p = p >>> ACC_SHIFT;
    return p[W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic signed [INT_W-1:0]   integ_q, integ_d;
  logic [FCW-1:0]            fast_cnt_q, fast_cnt_d;
  logic                      ptch_vld_q, ptch_vld_d;

  logic signed [W-1:0]       ptch_cur;
  logic signed [W-1:0]       ptch_acc;
  logic [W-1:0]              rt_offset;
  logic signed [W-1:0]       rt_comp;
  logic signed [INT_W-1:0]   step_mag;
  logic signed [INT_W-1:0]   step;
  logic signed [INT_W-1:0]   fused;

`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
  localparam int CW = W + CAL_LOG2;
  logic [CAL_LOG2-1:0]       cal_cnt_q, cal_cnt_d;
  logic signed [CW-1:0]      sum_q, sum_d;
  logic signed [CW-1:0]      sum_next;
  logic [W-1:0]              offset_q, offset_d;
  logic                      cal_done_q, cal_done_d;

  assign rt_offset = offset_q;
  assign sum_next  = sum_q + CW'($signed(ptch_rt));
`else
  assign rt_offset = PTCH_RT_OFFSET;
`endif

  assign ptch_cur = integ_q[INT_W-1:SHIFT];
  assign ptch_acc = accel_to_angle($signed(AZ - AZ_OFFSET));
  assign rt_comp  = $signed(ptch_rt - rt_offset);
  assign step_mag = (state_q == S_FAST) ? STEP_FAST : STEP_RUN;
  // A tie between the two angle estimates takes the negative step.
  assign step     = (ptch_acc > ptch_cur) ? step_mag : -step_mag;
  // The integrator wraps as two's complement. There is deliberately no saturation.
  assign fused    = integ_q - INT_W'(rt_comp) + step;

  always_comb begin
    state_d    = state_q;
    integ_d    = integ_q;
    fast_cnt_d = fast_cnt_q;
    ptch_vld_d = 1'b0;
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
    cal_cnt_d  = cal_cnt_q;
    sum_d      = sum_q;
    offset_d   = offset_q;
    cal_done_d = cal_done_q;
`endif
    if (vld) begin
      case (state_q)
        S_CAL: begin
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
          sum_d     = sum_next;
          cal_cnt_d = cal_cnt_q + 1'b1;
          if (&cal_cnt_q) begin
            // The average includes the closing sample. The integrator is
            // seeded so that ptch matches the accelerometer angle.
            offset_d   = sum_next[CW-1:CAL_LOG2];
            integ_d    = $signed({ptch_acc, {SHIFT{1'b0}}});
            sum_d      = '0;
            cal_done_d = 1'b1;
            state_d    = S_FAST;
          end
`else
          state_d = S_FAST;
`endif
        end
        S_FAST: begin
          integ_d    = fused;
          ptch_vld_d = 1'b1;
          if (fast_cnt_q == FCW'(FAST_CNT - 1)) begin
            fast_cnt_d = '0;
            state_d    = S_RUN;
          end else begin
            fast_cnt_d = fast_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          integ_d    = fused;
          ptch_vld_d = 1'b1;
        end
        default: state_d = S_FAST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
      state_q    <= S_CAL;
      cal_cnt_q  <= '0;
      sum_q      <= '0;
      offset_q   <= '0;
      cal_done_q <= 1'b0;
`else
      state_q    <= S_FAST;
`endif
      integ_q    <= '0;
      fast_cnt_q <= '0;
      ptch_vld_q <= 1'b0;
    end else begin
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
      cal_cnt_q  <= cal_cnt_d;
      sum_q      <= sum_d;
      offset_q   <= offset_d;
      cal_done_q <= cal_done_d;
`endif
      state_q    <= state_d;
      integ_q    <= integ_d;
      fast_cnt_q <= fast_cnt_d;
      ptch_vld_q <= ptch_vld_d;
    end
  end

  assign ptch     = ptch_cur;
  assign ptch_vld = ptch_vld_q;
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
  assign cal_done = cal_done_q;
`else
  assign cal_done = 1'b1;
`endif

endmodule

// File: tb/tb_inertial_integrator_gen.sv
// Self-checking bench for inertial_integrator_gen. It uses FAST_CNT=4 and
// CAL_LOG2=2. It works with or without INERTIAL_INTEGRATOR_GEN_CAL_EN.
module tb_inertial_integrator_gen;
  localparam int FCNT = 4;
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
  localparam int RST_CAL_DONE = 0;
`else
  localparam int RST_CAL_DONE = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        cal_done;

  int total = 0;
  int bad   = 0;

  inertial_integrator_gen #(.FAST_CNT(FCNT), .CAL_LOG2(2)) dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
    .ptch(ptch), .ptch_vld(ptch_vld), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  // Reference model. It counts accepted samples and computes the angle with
  // plain integer arithmetic.
  longint m_integ;
  int     m_fast, m_calcnt, m_sum, m_off;
  bit     m_caldone, m_vld;

  function automatic int s16(int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic longint wrap27(longint v);
    longint r;
    r = v & 64'h7FF_FFFF;
    if (r[26]) r = r - 64'h800_0000;
    return r;
  endfunction

  function automatic int accel(int az);
    int azc;
    azc = s16(az - 'hFE80);
    return s16((azc * 327) >>> 13);
  endfunction

  function automatic int ptch_of();
    return int'(m_integ >>> 11);
  endfunction

  function automatic void model_reset();
    m_integ = 0; m_fast = 0; m_calcnt = 0; m_sum = 0; m_vld = 0;
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
    m_off = 0; m_caldone = 0;
`else
    m_off = 'h3C2; m_caldone = 1;
`endif
  endfunction

  function automatic void model_sample(int rt, int az);
    int comp, k, step;
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
    if (m_calcnt < 4) begin
      m_sum += s16(rt);
      m_calcnt++;
      m_vld = 0;
      if (m_calcnt == 4) begin
        m_off     = s16(m_sum >>> 2);
        m_integ   = wrap27(longint'(accel(az)) * 2048);
        m_caldone = 1;
      end
      return;
    end
`endif
    comp = s16(rt - m_off);
    k    = (m_fast < FCNT) ? 13 : 10;
    m_fast++;
    step = (accel(az) > ptch_of()) ? (1 << k) : -(1 << k);
    m_integ = wrap27(m_integ - longint'(comp) + longint'(step));
    m_vld   = 1;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle. The model is updated and the outputs are compared just after the edge.
  task automatic cycle(bit v, logic [15:0] rt, logic [15:0] az);
    vld = v; ptch_rt = rt; AZ = az;
    @(posedge clk); #1;
    if (v) model_sample(int'(rt), int'(az));
    else   m_vld = 0;
    check("ptch", s16(int'(ptch)), ptch_of());
    check("ptch_vld", int'(ptch_vld), int'(m_vld));
    check("cal_done", int'(cal_done), int'(m_caldone));
  endtask

  // Assert reset mid-cycle with no clock edge in between, then check the
  // cleared outputs. vld is held high while rst is asserted.
  task automatic do_reset();
    #2 rst = 1'b1; vld = 1'b1; ptch_rt = 16'h1234; AZ = 16'h0268;
    #1;
    check("rst_ptch", s16(int'(ptch)), 0);
    check("rst_ptch_vld", int'(ptch_vld), 0);
    check("rst_cal_done", int'(cal_done), RST_CAL_DONE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; vld = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] rt;
    logic [15:0] az;
    int          exp_ptch;
  } vec_t;

  vec_t tbl[10];
  bit   saw_wrap;
  int   prev_p;

  initial begin
    // Hand-derived fused pitch, starting from integrator 0 with offset 0x03C2.
    // Samples 1-4 are FAST (step 8192); samples 5 onward are RUN (step 1024).
    tbl[0] = '{16'h03C2, 16'hFE80, -4};
    tbl[1] = '{16'h03C2, 16'hFE80,  0};
    tbl[2] = '{16'h03C2, 16'hFE80, -4};
    tbl[3] = '{16'h03C2, 16'hFE80,  0};
    tbl[4] = '{16'h03C2, 16'hFE80, -1};
    tbl[5] = '{16'h03C2, 16'hFE80,  0};
    tbl[6] = '{16'hFBC2, 16'hFE80,  0};
    tbl[7] = '{16'hFBC2, 16'hFE80,  1};
    tbl[8] = '{16'hFBC2, 16'hFE80,  1};
    tbl[9] = '{16'h03C2, 16'h0268,  2};

    rst = 1'b1; vld = 1'b0; ptch_rt = '0; AZ = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ptch", s16(int'(ptch)), 0);
    check("reset_ptch_vld", int'(ptch_vld), 0);
    check("reset_cal_done", int'(cal_done), RST_CAL_DONE);
    @(negedge clk);
    rst = 1'b0;

`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h03C2, 16'hFE80);
      check("cal_no_vld", int'(ptch_vld), 0);
    end
    check("cal_done_set", int'(cal_done), 1);
    check("cal_ptch", s16(int'(ptch)), 0);
`endif

    // Back-to-back table vectors cover FAST, the FAST to RUN change and RUN.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].rt, tbl[i].az);
      check($sformatf("tbl%0d_ptch", i), s16(int'(ptch)), tbl[i].exp_ptch);
      check($sformatf("tbl%0d_vld", i), int'(ptch_vld), 1);
    end

    // A cycle with no vld must leave the state untouched.
    cycle(1'b0, 16'h7FFF, 16'h7FFF);
    check("gap_hold", s16(int'(ptch)), 2);

    // Reset during operation, then check the first sample after release.
    cycle(1'b1, 16'h03C2, 16'hFE80);
    do_reset();
    cycle(1'b1, 16'h03C2, 16'hFE80);
`ifdef INERTIAL_INTEGRATOR_GEN_CAL_EN
    check("post_rst_cal1_vld", int'(ptch_vld), 0);
    check("post_rst_cal1_done", int'(cal_done), 0);
`else
    check("post_rst_vld", int'(ptch_vld), 1);
    check("post_rst_ptch", s16(int'(ptch)), -4);
`endif
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h03C2, 16'hFE80);

    // Rate offset of -32768 per sample drives the integrator through its wrap.
    saw_wrap = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      prev_p = s16(int'(ptch));
      cycle(1'b1, 16'h83C2, 16'hFE80);
      if (prev_p > 16000 && s16(int'(ptch)) < -16000) saw_wrap = 1'b1;
    end
    check("wrap_seen", int'(saw_wrap), 1);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [15:0] rt, az;
      bit v;
      v  = ($urandom_range(0, 3) != 0);
      rt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(16'h03C2 + $urandom_range(0, 4000) - 2000);
      az = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(16'hFE80 + $urandom_range(0, 400) - 200);
      cycle(v, rt, az);
    end

    vld = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
